// File: rtl/gesture_bbox_stats.sv
// Per-frame hand features from the dilated binary stream: foreground count, bounding box
// and integer centroid, published together with a one-cycle stats_valid during blanking.
module gesture_bbox_stats #(
    parameter int H_ACT   = 640,
    parameter int V_ACT   = 480,
    parameter int MIN_PIX = 256
) (
    input  logic        vga_clk,
    input  logic        rst,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic [11:0] dilate_data,
    output logic        hand_present,
    output logic [18:0] pix_cnt,
    output logic [9:0]  x_min,
    output logic [9:0]  x_max,
    output logic [9:0]  y_min,
    output logic [9:0]  y_max,
    output logic [9:0]  cx,
    output logic [9:0]  cy,
    output logic        stats_valid,
    output logic        busy
);

    localparam int DIV_BITS = 28;

    typedef enum logic [1:0] {IDLE, DIV, PUBLISH} state_t;

    typedef struct packed {
        logic [19:0] rem;
        logic [27:0] dq;
    } div_step_t;

    // One restoring-division step: quotient bits shift into dq as dividend bits shift out.
    function automatic div_step_t div_step(input logic [19:0] rem, input logic [27:0] dq,
                                           input logic [18:0] divisor);
        div_step_t   r;
        logic [19:0] trial;
        trial = {rem[18:0], dq[27]};
        if (trial >= {1'b0, divisor}) begin
            r.rem = trial - {1'b0, divisor};
            r.dq  = {dq[26:0], 1'b1};
        end else begin
            r.rem = trial;
            r.dq  = {dq[26:0], 1'b0};
        end
        return r;
    endfunction

    state_t      state, state_next;
    logic        active, fg, frame_start, frame_end;
    logic        frame_seen, end_q;
    logic        start_div, start_empty, div_last;
    logic [18:0] acc_cnt;
    logic [27:0] acc_sx, acc_sy;
    logic [9:0]  acc_xmin, acc_xmax, acc_ymin, acc_ymax;
    logic [18:0] sh_cnt;
    logic [9:0]  sh_xmin, sh_xmax, sh_ymin, sh_ymax;
    logic [19:0] rem_x, rem_y;
    logic [27:0] dq_x, dq_y;
    logic [4:0]  div_iter;
    div_step_t   step_x, step_y;
    logic        unused_bits;

    assign active      = (pixel_x < 10'(H_ACT)) && (pixel_y < 10'(V_ACT));
    assign fg          = active && dilate_data[11];
    assign frame_start = active && (pixel_x == 10'd0) && (pixel_y == 10'd0);
    assign frame_end   = active && (pixel_x == 10'(H_ACT - 1)) && (pixel_y == 10'(V_ACT - 1));
    assign unused_bits = ^dilate_data[10:0];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            frame_seen <= 1'b0;
            end_q      <= 1'b0;
            acc_cnt    <= '0;
            acc_sx     <= '0;
            acc_sy     <= '0;
            acc_xmin   <= '0;
            acc_xmax   <= '0;
            acc_ymin   <= '0;
            acc_ymax   <= '0;
        end else begin
            end_q <= frame_end && frame_seen;
            if (frame_start) begin
                frame_seen <= 1'b1;
                acc_cnt    <= {18'd0, fg};
                acc_sx     <= '0;
                acc_sy     <= '0;
                acc_xmin   <= fg ? 10'd0 : 10'h3FF;
                acc_ymin   <= fg ? 10'd0 : 10'h3FF;
                acc_xmax   <= '0;
                acc_ymax   <= '0;
            end else if (fg) begin
                acc_cnt <= acc_cnt + 19'd1;
                acc_sx  <= acc_sx + 28'(pixel_x);
                acc_sy  <= acc_sy + 28'(pixel_y);
                if (pixel_x < acc_xmin) acc_xmin <= pixel_x;
                if (pixel_x > acc_xmax) acc_xmax <= pixel_x;
                if (pixel_y < acc_ymin) acc_ymin <= pixel_y;
                if (pixel_y > acc_ymax) acc_ymax <= pixel_y;
            end
        end
    end

    // The first quotient bit is taken straight from the live totals in the hand-off cycle.
    assign start_div   = (state == IDLE) && end_q && (acc_cnt >= 19'(MIN_PIX));
    assign start_empty = (state == IDLE) && end_q && (acc_cnt < 19'(MIN_PIX));
    assign div_last    = (state == DIV) && (div_iter == 5'(DIV_BITS - 1));

    assign step_x = (state == DIV) ? div_step(rem_x, dq_x, sh_cnt) : div_step(20'd0, acc_sx, acc_cnt);
    assign step_y = (state == DIV) ? div_step(rem_y, dq_y, sh_cnt) : div_step(20'd0, acc_sy, acc_cnt);

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: state_next gets a default before the case so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_div)        state_next = DIV;
                else if (start_empty) state_next = PUBLISH;
            end
            DIV:     if (div_last) state_next = PUBLISH;
            PUBLISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            sh_cnt   <= '0;
            sh_xmin  <= '0;
            sh_xmax  <= '0;
            sh_ymin  <= '0;
            sh_ymax  <= '0;
            rem_x    <= '0;
            rem_y    <= '0;
            dq_x     <= '0;
            dq_y     <= '0;
            div_iter <= '0;
        end else if (start_div) begin
            sh_cnt   <= acc_cnt;
            sh_xmin  <= acc_xmin;
            sh_xmax  <= acc_xmax;
            sh_ymin  <= acc_ymin;
            sh_ymax  <= acc_ymax;
            rem_x    <= step_x.rem;
            dq_x     <= step_x.dq;
            rem_y    <= step_y.rem;
            dq_y     <= step_y.dq;
            div_iter <= 5'd1;
        end else if (state == DIV) begin
            rem_x    <= step_x.rem;
            dq_x     <= step_x.dq;
            rem_y    <= step_y.rem;
            dq_y     <= step_y.dq;
            div_iter <= div_iter + 5'd1;
        end
    end

    // Published registers change only on the edge that enters PUBLISH, so they hold otherwise.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            hand_present <= 1'b0;
            pix_cnt      <= '0;
            x_min        <= '0;
            x_max        <= '0;
            y_min        <= '0;
            y_max        <= '0;
            cx           <= '0;
            cy           <= '0;
        end else if (start_empty) begin
            hand_present <= 1'b0;
            pix_cnt      <= acc_cnt;
            x_min        <= '0;
            x_max        <= '0;
            y_min        <= '0;
            y_max        <= '0;
            cx           <= '0;
            cy           <= '0;
        end else if (div_last) begin
            hand_present <= 1'b1;
            pix_cnt      <= sh_cnt;
            x_min        <= sh_xmin;
            x_max        <= sh_xmax;
            y_min        <= sh_ymin;
            y_max        <= sh_ymax;
            cx           <= step_x.dq[9:0];
            cy           <= step_y.dq[9:0];
        end
    end

    assign stats_valid = (state == PUBLISH);
    assign busy        = (state == DIV) || start_div;

endmodule

// File: doc/gesture_bbox_stats.md
Name: gesture_bbox_stats

Overview:
- Consumes the dilated binary video stream and extracts per-frame hand features for the gesture classifier.
- Features: foreground pixel count, bounding box and integer centroid.
- Accumulates over the active 640x480 area in raster order.
- At frame end, a serial divider computes the centroid. All results are then published together with a one-cycle valid pulse, during vertical blanking.

Parameters:
- H_ACT, 640, active pixels per line
- V_ACT, 480, active lines per frame
- MIN_PIX, 256, minimum foreground count for hand_present=1

Ports:
- vga_clk  input  1  pixel clock
- rst  input  1  asynchronous active-high reset
- pixel_x  input  10  current column from the VGA timing counter
- pixel_y  input  10  current row from the VGA timing counter
- dilate_data  input  12  dilated pixel; bit 11 set = foreground (12'hfff / 12'h000)
- hand_present  output  1  last frame had pix_cnt >= MIN_PIX
- pix_cnt  output  19  foreground pixel count of the last frame
- x_min, x_max  output  10  bounding-box columns
- y_min, y_max  output  10  bounding-box rows
- cx, cy  output  10  centroid = floor(sum/pix_cnt)
- stats_valid  output  1  one-cycle pulse when the outputs above update
- busy  output  1  divider running

Behaviour:
- Reset (async, rst=1): all outputs 0; state IDLE; accumulators 0; frame_seen=0.
- active = (pixel_x < H_ACT) && (pixel_y < V_ACT); fg = active && dilate_data[11]. Outside active, nothing changes.
- Frame start (active, x=0, y=0): sets frame_seen=1. Accumulators are loaded with this pixel's contribution alone: cnt=fg, sum_x=0, sum_y=0. If fg: min/max = 0. If not fg: x_min/y_min = 10'h3FF, x_max/y_max = 0.
- Other active fg pixels:
  - cnt += 1; sum_x += pixel_x; sum_y += pixel_y.
  - x_min = min(x_min, x); x_max = max(x_max, x); same for y.
- Widths: cnt 19 b; sum_x, sum_y 28 b (max 639*307200 < 2^28). No saturation is needed.
- Frame end is cycle T, when active, x=H_ACT-1 and y=V_ACT-1 are sampled.
  - If frame_seen=0 (partial first frame after reset): nothing is published.
  - Otherwise, at T+1 the final accumulators (including pixel T) are copied into shadow registers. The live accumulators stay free for the next frame.
- State machine IDLE -> DIV -> PUBLISH -> IDLE:
  - IDLE: on frame end with frame_seen, go to DIV if shadow cnt >= MIN_PIX, else go to PUBLISH.
  - DIV: busy=1. Two parallel restoring dividers (sum_x/cnt, sum_y/cnt), one quotient bit per cycle, 28 iterations (cycles T+1..T+28). Quotients are truncated to 10 bits (they always fit).
  - PUBLISH: one cycle. Outputs update and stats_valid=1 at T+29 on the divide path, or at T+2 on the empty path. Returns to IDLE.
- Empty path (cnt < MIN_PIX):
  - hand_present=0; pix_cnt = shadow cnt.
  - x_min, x_max, y_min, y_max, cx, cy = 0.
  - No divide; division by zero can never occur.
- Outputs hold between stats_valid pulses.
- A frame start during DIV (blanking < 29 cycles) restarts only the live accumulators. The divider completes on the shadow values.
- A second frame end while busy is dropped: no stats_valid for that frame; the current divide finishes.
- Reset asserted mid-DIV: immediate return to reset state; no stats_valid.
- pixel_x/pixel_y are sampled with dilate_data on the same edge. Alignment of the upstream pipeline latency is the integrator's responsibility.

Test Plan:
- Rectangle fg x=100..199, y=50..149, full 640x480 frame -> pix_cnt=10000, bbox (100,199,50,149), cx=149, cy=99, hand_present=1, stats_valid exactly 29 cycles after the last active pixel.
- All-foreground frame -> pix_cnt=307200, bbox (0,639,0,479), cx=319, cy=239; no overflow.
- Frame with 255 fg pixels at (10..264, 20) -> hand_present=0, pix_cnt=255, bbox/centroid 0, stats_valid at T+2, busy never asserts.
- Fg pixels driven with pixel_x=700 or pixel_y=500 (blanking) plus a single 16x16 block at (0,0) -> pix_cnt=256, bbox (0,15,0,15), cx=7, cy=7; blanking pixels ignored.
- Release reset mid-frame at y=200; run 2 frames -> no stats_valid for the partial frame; the first full frame publishes correct values.
- Assert rst at T+10 during DIV -> all outputs 0 immediately, no stats_valid; the next full frame publishes correctly. Also: two consecutive frames with different blobs and 20-cycle blanking -> the second frame's values are not corrupted by the first frame's divide.
